// File: rtl/burst_pkg.sv
// Shared definitions for the SDRAM burst column-address path:
// burst-length codes, addressing modes and the generator FSM state type.
package burst_pkg;

    // Mode-register burst-length codes (100..110 are reserved).
    localparam logic [2:0] BL_1    = 3'b000;
    localparam logic [2:0] BL_2    = 3'b001;
    localparam logic [2:0] BL_4    = 3'b010;
    localparam logic [2:0] BL_8    = 3'b011;
    localparam logic [2:0] BL_PAGE = 3'b111;

    // Addressing modes.
    localparam logic ADDR_SEQ   = 1'b0;
    localparam logic ADDR_INTLV = 1'b1;

    // Column generator states.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burstStateT;

    // True for the reserved burst-length codes 100..110.
    function automatic logic isReservedCode(input logic [2:0] code);
        return (code == 3'b100) || (code == 3'b101) || (code == 3'b110);
    endfunction

endpackage

// File: rtl/burst_carry_mask.sv
// Carry-mask decoder: burst-length code and addressing mode -> COL_W-bit
// wrap mask. Bits set in the mask are the column bits that advance within
// the burst; bits clear are frozen from the starting column. Reserved codes
// decode like BL=1 (empty mask). Interleaved full page is not a defined
// mode, so interleaving is only enabled for fixed-length bursts.
module burst_carry_mask
    import burst_pkg::*;
#(
    parameter int COL_W = 8
) (
    input  logic [2:0]       blCode,
    input  logic             addrMode,
    output logic [COL_W-1:0] mask,
    output logic             fullPage,
    output logic             intlvEn
);

    // Decode the code into the existing carry-mask encoding.
    always_comb begin
        mask     = '0;
        fullPage = 1'b0;
        case (blCode)
            BL_1:    mask[2:0] = 3'b000;
            BL_2:    mask[2:0] = 3'b001;
            BL_4:    mask[2:0] = 3'b011;
            BL_8:    mask[2:0] = 3'b111;
            BL_PAGE: begin
                mask     = '1;
                fullPage = 1'b1;
            end
            default: mask = '0;
        endcase
        intlvEn = (addrMode == ADDR_INTLV) && !fullPage;
    end

endmodule

// File: rtl/burst_col_addr_gen.sv
// Burst column-address generator. Latches the starting column, burst-length
// code and addressing mode on Start, then presents one column per beat,
// wrapping inside the burst boundary given by the carry mask.
//
// Handshake: a beat transfers on a rising edge where ColValid and ColReady
// are both 1. ColValid never drops and ColAddr never changes while a beat
// is waiting for ColReady; ColReady may be driven independently of ColValid.
//
// Optional build macro BURST_CODE_CHECK_EN: adds ErrReserved, rejects Start
// with a reserved burst-length code and flags interleaved full page.
module burst_col_addr_gen
    import burst_pkg::*;
#(
    parameter int COL_W = 8
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [COL_W-1:0] StartCol,
    input  logic [2:0]       BurstLength,
    input  logic             AddrMode,
    input  logic             Terminate,
    input  logic             ColReady,
    output logic [COL_W-1:0] ColAddr,
    output logic             ColValid,
    output logic             ColLast,
`ifdef BURST_CODE_CHECK_EN
    output logic             ErrReserved,
`endif
    output logic             Busy
);

    burstStateT       state;
    burstStateT       nextState;
    logic [COL_W-1:0] startColQ;
    logic [2:0]       blCodeQ;
    logic             addrModeQ;
    logic [COL_W-1:0] cnt;
    logic [COL_W-1:0] mask;
    logic             fullPage;
    logic             intlvEn;
    logic             startAccept;
    logic             xfer;
    logic             rejectCode;
    logic [COL_W-1:0] seqLow;
    logic [COL_W-1:0] intlvLow;
    logic [COL_W-1:0] burstAddr;

`ifdef BURST_CODE_CHECK_EN
    assign rejectCode = isReservedCode(BurstLength);
`else
    assign rejectCode = 1'b0;
`endif

    burst_carry_mask #(.COL_W(COL_W)) uMask (
        .blCode   (blCodeQ),
        .addrMode (addrModeQ),
        .mask     (mask),
        .fullPage (fullPage),
        .intlvEn  (intlvEn)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and handshake outputs; Terminate and last-beat transfer
    // both end the burst, so their coincidence is just normal completion.
    always_comb begin
        nextState   = state;
        startAccept = 1'b0;
        xfer        = 1'b0;
        ColValid    = 1'b0;
        Busy        = 1'b0;
        ColLast     = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !rejectCode) begin
                    startAccept = 1'b1;
                    nextState   = BURST;
                end
            end
            BURST: begin
                ColValid = 1'b1;
                Busy     = 1'b1;
                ColLast  = !fullPage && (cnt == mask);
                xfer     = ColReady;
                if ((ColReady && ColLast) || Terminate) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Burst parameters are captured only on an accepted Start; the beat
    // counter advances on each transfer and wraps freely in full page.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            startColQ <= '0;
            blCodeQ   <= BL_1;
            addrModeQ <= ADDR_SEQ;
            cnt       <= '0;
        end else if (startAccept) begin
            startColQ <= StartCol;
            blCodeQ   <= BurstLength;
            addrModeQ <= AddrMode;
            cnt       <= '0;
        end else if (xfer) begin
            cnt <= cnt + COL_W'(1);
        end
    end

    // Column address: frozen upper bits from the start column, masked low
    // bits either counted up (sequential) or XOR-ed (interleaved).
    always_comb begin
        seqLow    = (startColQ + cnt) & mask;
        intlvLow  = (startColQ ^ cnt) & mask;
        burstAddr = (startColQ & ~mask) | (intlvEn ? intlvLow : seqLow);
        ColAddr   = ColValid ? burstAddr : '0;
    end

`ifdef BURST_CODE_CHECK_EN
    // One-cycle error pulse for a reserved code or interleaved full page.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            ErrReserved <= 1'b0;
        end else begin
            ErrReserved <= (state == IDLE) && Start &&
                           (isReservedCode(BurstLength) ||
                            ((BurstLength == BL_PAGE) && (AddrMode == ADDR_INTLV)));
        end
    end
`endif

endmodule
